// File: rtl/div_restoring_seq.sv
// div_restoring_seq: iterative restoring divider, one quotient bit per clock; `define DIV_SIGNED_EN for two's complement operands
module div_restoring_seq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] iv_dividend,
  input  logic [DATA_WIDTH-1:0] iv_divisor,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] ov_quot,
  output logic [DATA_WIDTH-1:0] ov_rem,
  output logic                  o_div_by_zero
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_rem, r_quot, r_dvs;
  logic r_dbz;
  logic w_acc, w_calc, w_zero;
  logic [W:0] w_sh, w_diff;
  logic w_borrow;
  logic [W-1:0] w_rem_n, w_quot_n, w_q_out, w_r_out, w_a_mag, w_b_mag;
  assign o_ready = r_state == IDLE;
  assign o_valid = r_state == DONE;
  assign w_acc = i_en & i_valid & o_ready;
  assign w_calc = i_en & (r_state == CALC);
  assign w_zero = iv_divisor == '0;
  assign w_sh = {r_rem, r_quot[W-1]};
  assign {w_borrow, w_diff} = {1'b0, w_sh} - {2'b0, r_dvs};
  assign w_rem_n = w_borrow ? w_sh[W-1:0] : w_diff[W-1:0];
  assign w_quot_n = {r_quot[W-2:0], ~w_borrow};
`ifdef DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  assign w_a_mag = iv_dividend[W-1] ? -iv_dividend : iv_dividend;
  assign w_b_mag = iv_divisor[W-1] ? -iv_divisor : iv_divisor;
  assign w_q_out = r_neg_q ? -w_quot_n : w_quot_n;
  assign w_r_out = r_neg_r ? -w_rem_n : w_rem_n;
`else
  assign w_a_mag = iv_dividend;
  assign w_b_mag = iv_divisor;
  assign w_q_out = w_quot_n;
  assign w_r_out = w_rem_n;
`endif
  // next state: accept, finish on last quotient bit, or release on consume
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = CALC;
    else if (w_calc && r_cnt == '0) w_next = DONE;
    else if (i_en && o_valid && i_ready) w_next = IDLE;
  end
  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  // datapath: capture operands, iterate, publish the result on the final step
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quot <= '0;
      r_dvs <= '0;
      r_dbz <= 1'b0;
      ov_quot <= '0;
      ov_rem <= '0;
      o_div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (w_acc) begin
      r_rem <= '0;
      r_quot <= w_zero ? iv_dividend : w_a_mag;
      r_dvs <= w_b_mag;
      r_dbz <= w_zero;
      r_cnt <= w_zero ? '0 : CW'(W - 1);
`ifdef DIV_SIGNED_EN
      r_neg_q <= iv_dividend[W-1] ^ iv_divisor[W-1];
      r_neg_r <= iv_dividend[W-1];
`endif
    end else if (w_calc) begin
      if (!r_dbz) begin
        r_rem <= w_rem_n;
        r_quot <= w_quot_n;
      end
      if (r_cnt == '0) begin
        ov_quot <= r_dbz ? '1 : w_q_out;
        ov_rem <= r_dbz ? r_quot : w_r_out;
        o_div_by_zero <= r_dbz;
      end else r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: tb/tb_div_restoring_seq.sv
// tb_div_restoring_seq: directed checks of the sequential restoring divider at DATA_WIDTH=16
module tb_div_restoring_seq;
  logic clk = 0, rst = 1, en = 1, i_valid = 0, i_ready = 0;
  logic [15:0] dvd = 0, dvs = 0, quot, rem;
  logic o_ready, o_valid, dbz;
  int n_vec = 0, n_err = 0;
  div_restoring_seq #(.DATA_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(i_valid), .o_ready(o_ready),
    .iv_dividend(dvd), .iv_divisor(dvs), .o_valid(o_valid), .i_ready(i_ready),
    .ov_quot(quot), .ov_rem(rem), .o_div_by_zero(dbz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                    input logic ed, input int elat, input int s_at, input int s_len, input int hold, input string tag);
    int lat;
    @(negedge clk);
    en = 1;
    lat = 0;
    while (!o_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rdy"}, 32'(o_ready), 1);
    i_valid = 1;
    dvd = a;
    dvs = b;
    @(posedge clk);
    #1;
    i_valid = 0;
    dvd = 16'hA5A5;
    dvs = 16'h0000;
    lat = 0;
    while (!o_valid && lat < 60) begin
      @(negedge clk);
      en = !(lat >= s_at && lat < s_at + s_len);
      @(posedge clk);
      #1;
      lat++;
    end
    en = 1;
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_quot"}, 32'(quot), 32'(eq));
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_dbz"}, 32'(dbz), 32'(ed));
    chk({tag, "_busy"}, 32'(o_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, {o_valid, o_ready, quot, 14'd0}, {1'b1, 1'b0, eq, 14'd0});
      chk({tag, "_hold_r"}, 32'(rem), 32'(er));
    end
    @(negedge clk);
    i_ready = 1;
    @(posedge clk);
    #1;
    i_ready = 0;
    chk({tag, "_cons"}, {30'd0, o_valid, o_ready}, 32'b01);
    chk({tag, "_keep"}, {quot, rem}, {eq, er});
  endtask
  initial begin
    #1;
    chk("rst_ctl", {30'd0, o_ready, o_valid}, 32'b10);
    chk("rst_out", {quot, rem}, 0);
    chk("rst_dbz", 32'(dbz), 0);
    @(negedge clk);
    rst = 0;
    en = 0;
    i_valid = 1;
    dvd = 16'd9;
    dvs = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("en_low_no_accept", {30'd0, o_ready, o_valid}, 32'b10);
    i_valid = 0;
    en = 1;
    op(16'd100, 16'd7, 16'd14, 16'd2, 0, 16, 99, 0, 0, "u100_7");
    op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 16, 99, 0, 0, "uffff_1");
    op(16'd5, 16'd9, 16'd0, 16'd5, 0, 16, 99, 0, 0, "u5_9");
    op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1, 1, 99, 0, 0, "dbz");
    op(16'd1000, 16'd10, 16'd100, 16'd0, 0, 16, 99, 0, 5, "bp");
    op(16'd50, 16'd6, 16'd8, 16'd2, 0, 19, 5, 3, 0, "stall");
`ifdef DIV_SIGNED_EN
    op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 0, 16, 99, 0, 0, "s_m7_2");
    op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 0, 16, 99, 0, 0, "s_7_m2");
    op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 0, 16, 99, 0, 0, "s_ovf");
`endif
    @(negedge clk);
    i_valid = 1;
    dvd = 16'd100;
    dvs = 16'd7;
    @(posedge clk);
    #1;
    i_valid = 0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("midrst_ctl", {30'd0, o_ready, o_valid}, 32'b10);
    chk("midrst_out", {quot, rem}, 0);
    chk("midrst_dbz", 32'(dbz), 0);
    @(negedge clk);
    rst = 0;
    op(16'd100, 16'd7, 16'd14, 16'd2, 0, 16, 99, 0, 0, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
